// File: rtl/xheep_load_bridge_if.sv
// Purpose: OBI write-channel bundle between the program-load bridge and the
//          X-HEEP OBI slave port.
// Signals:
//   req    - OBI request, held until granted
//   we     - write enable, 1 while req is high
//   be     - byte enables
//   addr   - write address
//   wdata  - write data
//   gnt    - OBI grant (from slave)
//   rvalid - OBI response valid (from slave)
// Modports: master (bridge side), slave (memory side).
interface xheep_load_bridge_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                    req;
    logic                    we;
    logic [DATA_WIDTH/8-1:0] be;
    logic [ADDR_WIDTH-1:0]   addr;
    logic [DATA_WIDTH-1:0]   wdata;
    logic                    gnt;
    logic                    rvalid;

    modport master (
        output req, we, be, addr, wdata,
        input  gnt, rvalid
    );

    modport slave (
        input  req, we, be, addr, wdata,
        output gnt, rvalid
    );
endinterface

// File: rtl/xheep_load_bridge.sv
// Purpose: FPGA-clock-domain end of the USB-to-X-HEEP program-load handshake.
//          Synchronises the USB-written address/instruction valid flags,
//          latches the qualified address or instruction, performs one OBI
//          write per instruction and then requests the flag clear through
//          active-low clear-request lines (four-phase handshake).
// Ports:
//   fpga_clk             - clock, all state on rising edge
//   rst_n                - asynchronous active-low reset
//   new_addr_valid_i     - async level flag: addr_i holds a new base address
//   instr_valid_i        - async level flag: instr_i holds a new instruction
//   addr_i / instr_i     - data qualified by the flags
//   rst_new_addr_valid_o - active-low clear request for the address flag
//   rst_instr_valid_o    - active-low clear request for the instruction flag
//   obi                  - OBI write channel (master modport)
//   busy_o               - 1 whenever the FSM is not idle
//   instr_count_o        - completed writes, wraps modulo 2^16
module xheep_load_bridge #(
    parameter int SYNC_STAGES = 2,
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_INCR   = 4
) (
    input  logic                  fpga_clk,
    input  logic                  rst_n,
    input  logic                  new_addr_valid_i,
    input  logic                  instr_valid_i,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic [DATA_WIDTH-1:0] instr_i,
    output logic                  rst_new_addr_valid_o,
    output logic                  rst_instr_valid_o,
    xheep_load_bridge_if.master   obi,
    output logic                  busy_o,
    output logic [15:0]           instr_count_o
);

    localparam logic [ADDR_WIDTH-1:0] INCR = ADDR_WIDTH'(ADDR_INCR);

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_LOAD_ADDR  = 3'd1,
        ST_ACK_ADDR   = 3'd2,
        ST_LOAD_INSTR = 3'd3,
        ST_OBI_REQ    = 3'd4,
        ST_OBI_RESP   = 3'd5,
        ST_ACK_INSTR  = 3'd6
    } state_e;

    state_e                  state_r;
    state_e                  state_next_s;
    logic [SYNC_STAGES-1:0]  a_sync_r;
    logic [SYNC_STAGES-1:0]  i_sync_r;
    logic                    a_s;
    logic                    i_s;
    logic [ADDR_WIDTH-1:0]   ptr_r;
    logic [DATA_WIDTH-1:0]   wdata_r;
    logic [15:0]             count_r;
    logic                    req_r;
    logic                    rst_addr_r;
    logic                    rst_instr_r;
    logic                    busy_r;
    logic                    write_done_s;

    assign a_s          = a_sync_r[SYNC_STAGES-1];
    assign i_s          = i_sync_r[SYNC_STAGES-1];
    assign write_done_s = (state_r == ST_OBI_RESP) && obi.rvalid;

    // Flag synchronisers: the FSM only ever looks at the last stage.
    always_ff @(posedge fpga_clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sync_r <= {SYNC_STAGES{1'b0}};
            i_sync_r <= {SYNC_STAGES{1'b0}};
        end else begin
            a_sync_r <= {a_sync_r[SYNC_STAGES-2:0], new_addr_valid_i};
            i_sync_r <= {i_sync_r[SYNC_STAGES-2:0], instr_valid_i};
        end
    end

    // FSM state register.
    always_ff @(posedge fpga_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic; the address flag wins when both flags are pending.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (a_s) begin
                    state_next_s = ST_LOAD_ADDR;
                end else if (i_s) begin
                    state_next_s = ST_LOAD_INSTR;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_LOAD_ADDR:  state_next_s = ST_ACK_ADDR;
            ST_ACK_ADDR: begin
                if (!a_s) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_ACK_ADDR;
                end
            end
            ST_LOAD_INSTR: state_next_s = ST_OBI_REQ;
            ST_OBI_REQ: begin
                // rvalid without a prior grant is not legal OBI and is ignored here.
                if (obi.gnt) begin
                    state_next_s = ST_OBI_RESP;
                end else begin
                    state_next_s = ST_OBI_REQ;
                end
            end
            ST_OBI_RESP: begin
                if (obi.rvalid) begin
                    state_next_s = ST_ACK_INSTR;
                end else begin
                    state_next_s = ST_OBI_RESP;
                end
            end
            ST_ACK_INSTR: begin
                // Staying here until the USB side drops the flag is what
                // guarantees each instruction is written exactly once.
                if (!i_s) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_ACK_INSTR;
                end
            end
            default: state_next_s = ST_IDLE;
        endcase
    end

    // Datapath and registered outputs; outputs are decoded from the next
    // state so they line up with the state register and never glitch.
    always_ff @(posedge fpga_clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_r       <= {ADDR_WIDTH{1'b0}};
            wdata_r     <= {DATA_WIDTH{1'b0}};
            count_r     <= 16'd0;
            req_r       <= 1'b0;
            rst_addr_r  <= 1'b1;
            rst_instr_r <= 1'b1;
            busy_r      <= 1'b0;
        end else begin
            // A new base address replaces the pointer rather than offsetting it.
            if (state_r == ST_LOAD_ADDR) begin
                ptr_r <= addr_i;
            end else if (write_done_s) begin
                ptr_r <= ptr_r + INCR;
            end
            if (state_r == ST_LOAD_INSTR) begin
                wdata_r <= instr_i;
            end
            if (write_done_s) begin
                count_r <= count_r + 16'd1;
            end
            req_r       <= (state_next_s == ST_OBI_REQ);
            rst_addr_r  <= (state_next_s != ST_ACK_ADDR);
            rst_instr_r <= (state_next_s != ST_ACK_INSTR);
            busy_r      <= (state_next_s != ST_IDLE);
        end
    end

    assign obi.req              = req_r;
    assign obi.we               = req_r;
    assign obi.be               = {(DATA_WIDTH/8){1'b1}};
    assign obi.addr             = ptr_r;
    assign obi.wdata            = wdata_r;
    assign rst_new_addr_valid_o = rst_addr_r;
    assign rst_instr_valid_o    = rst_instr_r;
    assign busy_o               = busy_r;
    assign instr_count_o        = count_r;

endmodule

// File: tb/tb_xheep_load_bridge.sv
// Purpose: self-checking bench for xheep_load_bridge. A table of address /
// instruction operations drives the USB-side flags while the bench plays the
// OBI slave; expected writes are queued when an instruction is raised and
// compared when the DUT's request is granted. Hand-written sequences cover
// simultaneous flags and reset during an outstanding request.
module tb_xheep_load_bridge;

    localparam int SYNC     = 2;
    localparam int SEL_REQ  = 0;
    localparam int SEL_RA   = 1;
    localparam int SEL_RI   = 2;
    localparam int SEL_BUSY = 3;

    typedef struct {
        bit          is_addr;
        logic [31:0] value;
        int          gnt_dly;
        int          hold;
        logic [31:0] exp_addr;
        logic [15:0] exp_cnt;
    } vec_t;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    logic        fpga_clk = 1'b0;
    logic        rst_n    = 1'b0;
    logic        new_addr_valid_i = 1'b0;
    logic        instr_valid_i    = 1'b0;
    logic [31:0] addr_i  = 32'h0;
    logic [31:0] instr_i = 32'h0;
    logic        rst_new_addr_valid_o;
    logic        rst_instr_valid_o;
    logic        busy_o;
    logic [15:0] instr_count_o;

    int  errors = 0;
    int  checks = 0;
    int  wr_cnt = 0;
    wr_t sb_q[$];
    vec_t vecs[9];

    xheep_load_bridge_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) obi ();

    xheep_load_bridge #(
        .SYNC_STAGES(SYNC), .ADDR_WIDTH(32), .DATA_WIDTH(32), .ADDR_INCR(4)
    ) dut (
        .fpga_clk             (fpga_clk),
        .rst_n                (rst_n),
        .new_addr_valid_i     (new_addr_valid_i),
        .instr_valid_i        (instr_valid_i),
        .addr_i               (addr_i),
        .instr_i              (instr_i),
        .rst_new_addr_valid_o (rst_new_addr_valid_o),
        .rst_instr_valid_o    (rst_instr_valid_o),
        .obi                  (obi),
        .busy_o               (busy_o),
        .instr_count_o        (instr_count_o)
    );

    always #5 fpga_clk = ~fpga_clk;

    // Count accepted OBI writes (request and grant on the same edge).
    always @(posedge fpga_clk) begin
        if (obi.req === 1'b1 && obi.gnt === 1'b1) wr_cnt <= wr_cnt + 1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic logic sig(input int sel);
        case (sel)
            SEL_REQ: return obi.req;
            SEL_RA:  return rst_new_addr_valid_o;
            SEL_RI:  return rst_instr_valid_o;
            default: return busy_o;
        endcase
    endfunction

    // Count negedges until the selected output reaches val; -1 on timeout.
    task automatic wait_sig(input int sel, input logic val, input int budget, output int cyc);
        for (int n = 1; n <= budget; n++) begin
            @(negedge fpga_clk);
            if (sig(sel) === val) begin
                cyc = n;
                return;
            end
        end
        cyc = -1;
        checks++;
        errors++;
        $display("FAIL timeout sel=%0d: waited %0d cycles for level %0b", sel, budget, val);
    endtask

    task automatic do_addr(input logic [31:0] a, input int hold);
        int cyc;
        int bad;
        int w0;
        w0 = wr_cnt;
        addr_i = a;
        new_addr_valid_i = 1'b1;
        wait_sig(SEL_RA, 1'b0, 20, cyc);
        chk("addr_clr_latency", cyc, SYNC + 2);
        chk("addr_busy", busy_o, 1'b1);
        bad = 0;
        repeat (hold) begin
            @(negedge fpga_clk);
            if (rst_new_addr_valid_o !== 1'b0 || obi.req !== 1'b0) bad++;
        end
        chk("addr_clr_held", bad, 0);
        new_addr_valid_i = 1'b0;
        wait_sig(SEL_RA, 1'b1, 20, cyc);
        chk("addr_release_latency", cyc, SYNC + 1);
        chk("addr_no_obi", wr_cnt - w0, 0);
    endtask

    // Act as OBI slave for one write, starting at a negedge with req high.
    task automatic serve_obi(input int gnt_dly);
        int  bad;
        wr_t e;
        bad = 0;
        repeat (gnt_dly) begin
            @(negedge fpga_clk);
            if (obi.req !== 1'b1) bad++;
        end
        chk("req_held_until_gnt", bad, 0);
        obi.gnt = 1'b1;
        if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL sb_empty: write to 0x%08h with no expected entry", obi.addr);
        end else begin
            e = sb_q.pop_front();
            chk("obi_addr", obi.addr, e.addr);
            chk("obi_wdata", obi.wdata, e.data);
        end
        chk("obi_be", {28'h0, obi.be}, 32'hF);
        chk("obi_we", obi.we, 1'b1);
        @(negedge fpga_clk);
        obi.gnt = 1'b0;
        chk("req_drop_after_gnt", obi.req, 1'b0);
        obi.rvalid = 1'b1;
        @(negedge fpga_clk);
        obi.rvalid = 1'b0;
        chk("instr_clr_low", rst_instr_valid_o, 1'b0);
    endtask

    task automatic do_instr(input logic [31:0] d, input int gnt_dly, input int hold,
                            input logic [31:0] exp_addr, input logic [15:0] exp_cnt,
                            input int exp_lat);
        int cyc;
        int bad;
        int w0;
        w0 = wr_cnt;
        sb_q.push_back('{exp_addr, d});
        instr_i = d;
        instr_valid_i = 1'b1;
        wait_sig(SEL_REQ, 1'b1, 30, cyc);
        chk("req_latency", cyc, exp_lat);
        serve_obi(gnt_dly);
        chk("instr_count", instr_count_o, exp_cnt);
        bad = 0;
        repeat (hold) begin
            @(negedge fpga_clk);
            if (rst_instr_valid_o !== 1'b0 || busy_o !== 1'b1 || obi.req !== 1'b0) bad++;
        end
        chk("instr_clr_held", bad, 0);
        instr_valid_i = 1'b0;
        wait_sig(SEL_RI, 1'b1, 20, cyc);
        chk("instr_release_latency", cyc, SYNC + 1);
        chk("single_write", wr_cnt - w0, 1);
        chk("busy_idle", busy_o, 1'b0);
    endtask

    initial begin
        int cyc;
        int w0;
        obi.gnt = 1'b0;
        obi.rvalid = 1'b0;

        //          is_addr value          gnt hold exp_addr       exp_cnt
        vecs[0] = '{1'b0, 32'h1111_1111, 1, 2,  32'h0000_0000, 16'd1};
        vecs[1] = '{1'b1, 32'h0000_0180, 0, 4,  32'h0,         16'd0};
        vecs[2] = '{1'b0, 32'h0000_0013, 3, 2,  32'h0000_0180, 16'd2};
        vecs[3] = '{1'b0, 32'h00A0_0093, 3, 2,  32'h0000_0184, 16'd3};
        vecs[4] = '{1'b1, 32'hFFFF_FFFC, 0, 2,  32'h0,         16'd0};
        vecs[5] = '{1'b0, 32'hDEAD_BEEF, 0, 2,  32'hFFFF_FFFC, 16'd4};
        vecs[6] = '{1'b0, 32'h1234_5678, 1, 2,  32'h0000_0000, 16'd5};
        vecs[7] = '{1'b1, 32'h0000_1000, 0, 3,  32'h0,         16'd0};
        vecs[8] = '{1'b0, 32'hCAFE_F00D, 2, 50, 32'h0000_1000, 16'd6};

        // Reset state.
        repeat (3) @(negedge fpga_clk);
        chk("rst_req", obi.req, 1'b0);
        chk("rst_clr_addr", rst_new_addr_valid_o, 1'b1);
        chk("rst_clr_instr", rst_instr_valid_o, 1'b1);
        chk("rst_addr", obi.addr, 32'h0);
        chk("rst_wdata", obi.wdata, 32'h0);
        chk("rst_busy", busy_o, 1'b0);
        chk("rst_count", instr_count_o, 16'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge fpga_clk);

        // Table-driven operations.
        for (int k = 0; k < 9; k++) begin
            if (vecs[k].is_addr) begin
                do_addr(vecs[k].value, vecs[k].hold);
                chk("busy_after_addr", busy_o, 1'b0);
            end else begin
                do_instr(vecs[k].value, vecs[k].gnt_dly, vecs[k].hold,
                         vecs[k].exp_addr, vecs[k].exp_cnt, SYNC + 2);
            end
            repeat (2) @(negedge fpga_clk);
        end

        // Both flags raised together: address first, then one write to it.
        w0 = wr_cnt;
        addr_i = 32'h0000_2000;
        instr_i = 32'hABCD_0001;
        new_addr_valid_i = 1'b1;
        instr_valid_i = 1'b1;
        wait_sig(SEL_RA, 1'b0, 20, cyc);
        chk("both_addr_latency", cyc, SYNC + 2);
        repeat (3) @(negedge fpga_clk);
        chk("both_no_req_during_addr", obi.req, 1'b0);
        new_addr_valid_i = 1'b0;
        chk("both_no_write_yet", wr_cnt - w0, 0);
        do_instr(32'hABCD_0001, 2, 2, 32'h0000_2000, 16'd7, SYNC + 3);
        repeat (2) @(negedge fpga_clk);

        // Reset while a request waits for grant; flag stays high throughout.
        instr_i = 32'h55AA_55AA;
        instr_valid_i = 1'b1;
        wait_sig(SEL_REQ, 1'b1, 20, cyc);
        repeat (2) @(negedge fpga_clk);
        chk("pre_rst_req", obi.req, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_req", obi.req, 1'b0);
        chk("mid_rst_clr_addr", rst_new_addr_valid_o, 1'b1);
        chk("mid_rst_clr_instr", rst_instr_valid_o, 1'b1);
        chk("mid_rst_busy", busy_o, 1'b0);
        chk("mid_rst_count", instr_count_o, 16'd0);
        chk("mid_rst_ptr", obi.addr, 32'h0);
        sb_q.delete();
        @(negedge fpga_clk);
        @(negedge fpga_clk);
        rst_n = 1'b1;
        do_instr(32'h55AA_55AA, 1, 3, 32'h0000_0000, 16'd1, SYNC + 2);

        chk("sb_drained", sb_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
